// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler for four requesters on the 8-bit tiny pin interface.
// Define ARB_TIMEOUT_EN to enable the MAX_HOLD grant timeout and the tmo pulse.
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 15
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  logic       clk, rst_n, done, hold;
  logic [3:0] req;
  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign req   = io_in[5:2];
  assign done  = io_in[6];
  assign hold  = io_in[7];

  state_t     state;
  logic [1:0] ptr, idx, win, pos;
  logic [3:0] gnt;
  logic       busy, tmo, found, rel_norm, rel_tmo;

  // First set request at or after ptr, wrapping.
  always_comb begin
    win   = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pos = ptr + 2'(i);
      if (!found && req[pos]) begin
        win   = pos;
        found = 1'b1;
      end
    end
  end

  assign rel_norm = done || !req[idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign rel_tmo = (cnt == 8'(MAX_HOLD - 1)) && !hold;
`else
  assign rel_tmo = 1'b0;
`endif

  assign io_out = {tmo, busy, idx, gnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      tmo   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        GRANT: begin
          if (rel_norm || rel_tmo) begin
            state <= RELEASE;
            gnt   <= '0;
            ptr   <= idx + 2'd1;
            busy  <= 1'b1;
            // A timeout coinciding with done/withdrawal is a normal release.
            tmo   <= rel_tmo && !rel_norm;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else begin
            tmo <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!hold) cnt <= cnt + 8'd1;
`endif
          end
        end
        default: begin
          tmo <= 1'b0;
          if (!hold && found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win;
            idx   <= win;
            busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Randomized scoreboard bench for rr_grant_scheduler; the reference model tracks
// owner / last winner / pointer / held cycles directly from the arbitration rules.
module tb_rr_grant_scheduler;

  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_s = 1'b1, done_s = 1'b0, hold_s = 1'b0;
  logic [3:0] req_s = 4'h0;
  logic [7:0] io_in, io_out;

  assign io_in = {hold_s, done_s, req_s, rst_s, clk};

  rr_grant_scheduler #(.MAX_HOLD(MH)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int total = 0, bad = 0, ncyc = 0;
  logic [7:0] expq[$];

  // Reference model state
  int owner = -1, last = 0, rptr = 0, held = 0;
  bit gap = 0, tmo_m = 0;

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = 8'h00;
    if (owner >= 0) o[owner] = 1'b1;
    o[5:4] = 2'(last);
    o[6]   = (owner >= 0) || gap;
    o[7]   = tmo_m;
    return o;
  endfunction

  task automatic model_reset();
    owner = -1; last = 0; rptr = 0; held = 0; gap = 0; tmo_m = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d, input logic h);
    bit norm, to;
    if (owner >= 0) begin
      norm = d || !r[owner];
      to   = TO_EN && (held == MH - 1) && !h;
      if (norm || to) begin
        rptr  = (owner + 1) % 4;
        owner = -1;
        gap   = 1;
        held  = 0;
        tmo_m = to && !norm;
      end else begin
        tmo_m = 0;
        if (!h) held++;
      end
    end else begin
      tmo_m = 0;
      gap   = 0;
      if (!h && r != 0) begin
        for (int k = 0; k < 4; k++)
          if (owner < 0 && r[(rptr + k) % 4]) owner = (rptr + k) % 4;
        last = owner;
        held = 0;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic d, input logic h);
    @(negedge clk);
    rst_s = 1'b1; req_s = r; done_s = d; hold_s = h;
    model_step(r, d, h);
    expq.push_back(model_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_s = 1'b0;
    model_reset();
    expq.push_back(8'h00);
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got %h exp 00", io_out);
    end
  endtask

  // Monitor: every edge the DUT presents a registered output word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        logic [7:0] e;
        e = expq.pop_front();
        ncyc++;
        total++;
        if (io_out !== e) begin
          bad++;
          $display("FAIL io_out cycle %0d: got %h exp %h", ncyc, io_out, e);
        end
      end
    end
  end

  initial begin
    req_s = 4'hF;
    do_reset();
    cyc(4'hF, 0, 0);
    // Rotation with done pulses
    repeat (5) begin
      cyc(4'hF, 0, 0);
      cyc(4'hF, 1, 0);
      cyc(4'hF, 0, 0);
    end
    // Single requester timeout
    do_reset();
    repeat (14) cyc(4'h1, 0, 0);
    // Collision of done with the last hold cycle
    do_reset();
    repeat (3) cyc(4'h1, 0, 0);
    cyc(4'h1, 1, 0);
    repeat (4) cyc(4'h2, 0, 0);
    // Hold in idle, then hold mid-grant
    do_reset();
    repeat (3) cyc(4'h4, 0, 1);
    repeat (2) cyc(4'h4, 0, 0);
    repeat (3) cyc(4'h4, 0, 1);
    repeat (8) cyc(4'h4, 0, 0);
    // Reset while requester 3 owns the grant
    do_reset();
    repeat (2) cyc(4'h8, 0, 0);
    do_reset();
    repeat (3) cyc(4'hA, 0, 0);
    // Long persistent grant
    do_reset();
    repeat (300) cyc(4'h1, 0, 0);
    // Random traffic with sticky requests
    begin
      logic [3:0] r;
      r = 4'hF;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) == 0) do_reset();
        else cyc(r, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      end
    end
    begin
      int w;
      w = 0;
      while (expq.size() > 0 && w < 10) begin
        @(posedge clk);
        w++;
      end
      #2;
      if (expq.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending exp 0", expq.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin arbiter that time-shares one downstream resource among four requesters through the 8-bit Tiny Tapeout pin interface. Requests arrive on `io_in`; a registered one-hot grant, the granted index, a busy flag and a timeout pulse go out on `io_out`. A grant ends on an explicit `done`, when the request is withdrawn, or, optionally, on a hold-time limit. It sits directly under the chip top-level pins and sequences whichever shared datapath the other project logic exposes.

## Interface
- `MAX_HOLD`, default 15: maximum grant length in cycles when the timeout is compiled in. Legal range is 1..255.
- `io_in[0]`  input  1: `clk`, the only clock. All logic is on the rising edge.
- `io_in[1]`  input  1: `rst_n`, asynchronous active-low reset.
- `io_in[5:2]`  input  4: `req[3:0]`, level requests, one bit per requester.
- `io_in[6]`  input  1: `done`. The current owner releases the grant.
- `io_in[7]`  input  1: `hold`. Pauses the hold counter and inhibits new grants.
- `io_out[3:0]`  output  4: `gnt[3:0]`, one-hot grant, registered.
- `io_out[5:4]`  output  2: `idx`, index of the current or most recent grant.
- `io_out[6]`  output  1: `busy`. High when the state is not IDLE.
- `io_out[7]`  output  1: `tmo`, a one-cycle pulse on a forced release.

## Operation
- **States:** IDLE, GRANT, RELEASE. Internal registers are the 2-bit round-robin pointer `ptr` and the 8-bit hold counter `cnt`.
- **Reset (rst_n=0):**
  - Takes effect immediately, without waiting for a clock edge.
  - State=IDLE, `ptr`=0, `cnt`=0.
  - All outputs are 0: `io_out`=0x00.
  - Reset asserted mid-grant drops `gnt` at once.
- **Arbitration (IDLE or RELEASE):**
  - Applies when `hold`=0 and `req`≠0.
  - Select the first set `req` bit searching `ptr`, `ptr+1`, …, wrapping mod 4.
  - Next state is GRANT, with `gnt` one-hot of the winner, `idx`=winner and `cnt`=0.
- **No arbitration:** if `req`=0 or `hold`=1, next state is IDLE (from RELEASE too).
- **GRANT, release conditions** (evaluated each edge):
  - (a) `done`=1.
  - (b) `req[idx]`=0.
  - (c) timeout: `cnt`==MAX_HOLD-1 and `hold`=0.
- **On release:**
  - Next state is RELEASE, `gnt`=0, `ptr`=`idx`+1 mod 4, `cnt`=0.
  - `tmo`=1 only if (c) alone caused the release.
- **No release:** `cnt` increments when `hold`=0 and freezes when `hold`=1. `hold` never blocks (a) or (b).
- **Simultaneous events:**
  - `done` or request withdrawal together with (c) counts as a normal release: `tmo` stays 0.
  - `done` while IDLE or RELEASE is ignored.
  - Requests changing on a grant edge are sampled only at that edge.
- **RELEASE:** `gnt`=0, one-cycle dead gap guaranteeing a break between owners. Arbitration runs in this state exactly as in IDLE.
- **Output hold rules:**
  - `idx` keeps its last value while no grant is active.
  - `busy`=1 in GRANT and RELEASE.
- **Counter width:** the counter is 8 bits. MAX_HOLD=1 gives a single-cycle grant.

## Timing
- **Grant latency:**
  - `req` sampled at edge N gives `gnt` valid after edge N.
  - Minimum request-to-grant is 1 cycle from IDLE.
- **Grant length:**
  - Normal release: `gnt` drops after the edge that samples `done`=1 or `req[idx]`=0, so a grant lasts at least 1 cycle.
  - Timeout: `gnt` is high for exactly MAX_HOLD non-held cycles.
- **Gap between owners:** exactly 1 cycle (RELEASE). Back-to-back grants of the same requester are spaced the same way.
- **`tmo`:** high only in the RELEASE cycle that follows a timeout.
- **Outputs:** all outputs are registered, with no combinational path from `io_in` to `io_out` except through the async reset.

## Configuration
- **`ARB_TIMEOUT_EN` defined:** release condition (c) is active and `tmo` is driven as specified above.
- **`ARB_TIMEOUT_EN` undefined:**
  - Condition (c) is removed, so grants last until `done` or request withdrawal.
  - `io_out[7]` is tied to 0.
  - `cnt` is not implemented, and `MAX_HOLD` is ignored.

## Test plan
- **Reset:** rst_n=0 with req=0xF → `io_out`=0x00 immediately. After rst_n=1, the first grant goes to req0: `gnt`=0x1, `idx`=0.
- **Timeout, single requester:** MAX_HOLD=4, `ARB_TIMEOUT_EN` defined, req=0x1 held → `gnt`=0x1 for 4 cycles, then one cycle with `gnt`=0 and `tmo`=1, then `gnt`=0x1 again.
- **Rotation:** req=0xF held, `done` pulsed one cycle in every grant → grant order 0,1,2,3,0, each separated by one dead cycle, `busy` held high throughout.
- **Collision:** MAX_HOLD=4, `done`=1 on the 4th grant cycle → `gnt` drops, `tmo` stays 0, `ptr` advances.
- **Hold:**
  - `hold`=1 in IDLE with req=0x4 → no grant, `busy`=0.
  - `hold` released → `gnt`=0x4 next cycle.
  - `hold`=1 for 3 cycles mid-grant with MAX_HOLD=4 → grant lasts 7 cycles.
- **Reset mid-operation and macro off:**
  - rst_n pulsed low while `gnt`=0x8 → `io_out`=0 without a clock edge. Next grant with req=0xA is 0x2.
  - With `ARB_TIMEOUT_EN` undefined, a grant persists for 300 cycles and `io_out[7]` stays 0.
